mem_read_arbiter: RTL and testbench

- Shares one Avalon-MM read port (mem_wrapper) between NUM_REQ fetch-style requesters, such as several tile fetchers feeding the MAC array.
- Arbitrates round-robin and issues reads with pipelining, up to MAX_OUT outstanding.
- Tracks the owner of each outstanding read in an in-order ID FIFO and routes each readdatavalid beat back to the requester that issued it.

---
 rtl/mem_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one pipelined Avalon-MM read port between NUM_REQ requesters.
// Owners of outstanding reads are queued in order so each readdatavalid beat returns to its issuer.
module mem_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_OUT    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic                          mem_read,
    input  logic                          mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]         mem_readdata,
    input  logic                          mem_readdatavalid,
    output logic                          busy,
    output logic                          err_unexpected
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    localparam logic [CW-1:0]      MAX_OUT_C = CW'(MAX_OUT);
    localparam logic [OW-1:0]      LAST_REQ  = OW'(NUM_REQ - 1);
    localparam logic [PW-1:0]      LAST_SLOT = PW'(MAX_OUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic [OW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           reserved_q, reserved_d;
    logic                    err_q, err_d;

    logic [OW-1:0]           fifo_mem [MAX_OUT];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic                    accept;
    logic                    sel_window;
    logic                    credit_ok;
    logic                    select;
    logic                    found;
    logic [OW-1:0]           winner;
    logic [NUM_REQ-1:0]      owner_oh;
    logic [NUM_REQ-1:0]      candidates;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    credit_ret;

    // A command is accepted in any ISSUE cycle the slave does not stall.
    assign accept     = (state_q == ST_ISSUE) && !mem_waitrequest;
    assign owner_oh   = ONE_HOT0 << owner_q;
    assign sel_window = (state_q == ST_IDLE) || accept;
    assign candidates = req_read & ~(accept ? owner_oh : '0);
    assign credit_ok  = (reserved_q < MAX_OUT_C);
    assign select     = sel_window && credit_ok && found;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == MAX_OUT_C);
    assign pop        = mem_readdatavalid && !fifo_empty;
    assign push       = accept && (!fifo_full || pop);
    assign credit_ret = mem_readdatavalid && (reserved_q != '0);

    assign mem_read       = (state_q == ST_ISSUE);
    assign mem_address    = addr_q;
    assign req_gnt        = accept ? owner_oh : '0;
    assign rsp_valid      = pop ? (ONE_HOT0 << fifo_mem[rd_ptr_q]) : '0;
    assign rsp_data       = mem_readdata;
    assign busy           = (reserved_q != '0);
    assign err_unexpected = err_q;

    // Search upward from the priority pointer, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && candidates[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        reserved_d = reserved_q;
        err_d      = err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (sel_window) begin
            if (select) begin
                state_d = ST_ISSUE;
                addr_d  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                owner_d = winner;
                ptr_d   = (winner == LAST_REQ) ? '0 : winner + 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Credits are reserved at selection, so a stalled command still holds its slot.
        case ({select, credit_ret})
            2'b10:   reserved_d = reserved_q + 1'b1;
            2'b01:   reserved_d = reserved_q - 1'b1;
            default: reserved_d = reserved_q;
        endcase

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (mem_readdatavalid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            reserved_q <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            reserved_q <= reserved_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the ID storage is not reset; count_q gates every read of it, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= owner_q;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: directed scenarios plus a randomized run against
// a memory model and per-requester expected-data queues.
module tb_mem_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 4;
    localparam int DW      = 64;
    localparam int MAX_OUT = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_read;
    logic [NUM_REQ*AW-1:0]  req_addr;
    logic [NUM_REQ-1:0]     req_gnt;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [DW-1:0]          rsp_data;
    logic [AW-1:0]          mem_address;
    logic                   mem_read;
    logic                   mem_waitrequest;
    logic [DW-1:0]          mem_readdata;
    logic                   mem_readdatavalid;
    logic                   busy;
    logic                   err_unexpected;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_addr(req_addr), .req_gnt(req_gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    typedef struct { int req; logic [DW-1:0] data; } exp_t;
    typedef struct { logic [AW-1:0] addr; int ready; } pend_t;

    int              errors = 0;
    int              checks = 0;
    logic [DW-1:0]   words [16];
    bit              req_active [NUM_REQ];
    logic [AW-1:0]   req_av [NUM_REQ];
    exp_t            exp_q [$];
    pend_t           pend_q [$];
    int              gnt_log [$];
    int              rsp_log [$];
    int              cyc = 0;
    bit              hold_dv = 0;
    bit              force_dv = 0;
    bit              rand_mode = 0;
    int              wr_hold = 0;

    logic [NUM_REQ-1:0] s_gnt, s_rsp;
    logic               s_mem_read, s_busy, s_err;
    logic [AW-1:0]      s_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (v[k]) r = k;
        return r;
    endfunction

    function automatic bit any_active();
        bit a = 0;
        for (int k = 0; k < NUM_REQ; k++) a |= req_active[k];
        return a;
    endfunction

    task automatic request(input int i, input logic [AW-1:0] a);
        req_active[i] = 1'b1;
        req_av[i]     = a;
        exp_q.push_back('{req: i, data: words[a]});
    endtask

    // One bus cycle: drive at the falling edge, sample shortly after, update the environment.
    task automatic tick();
        int    lat;
        pend_t p;
        @(negedge clk);
        cyc++;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        if (force_dv) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = {$urandom, $urandom};
            force_dv          = 1'b0;
        end else if (!hold_dv && pend_q.size() > 0 && pend_q[0].ready <= cyc &&
                     (!rand_mode || $urandom_range(3) != 0)) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = words[pend_q[0].addr];
            pend_q.delete(0);
        end
        if (wr_hold > 0 && mem_read) begin
            mem_waitrequest = 1'b1;
            wr_hold--;
        end else begin
            mem_waitrequest = rand_mode ? ($urandom_range(3) == 0) : 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_read[i]          = req_active[i];
            req_addr[i*AW +: AW] = req_av[i];
        end
        #1;
        s_gnt      = req_gnt;
        s_rsp      = rsp_valid;
        s_mem_read = mem_read;
        s_busy     = busy;
        s_err      = err_unexpected;
        s_addr     = mem_address;
        if (mem_read && !mem_waitrequest) begin
            lat = rand_mode ? int'($urandom_range(1, 4)) : 2;
            p.addr  = mem_address;
            p.ready = cyc + lat;
            if (pend_q.size() > 0 && pend_q[pend_q.size()-1].ready > p.ready)
                p.ready = pend_q[pend_q.size()-1].ready;
            pend_q.push_back(p);
            check("outstanding_limit", 64'(pend_q.size() <= MAX_OUT), 64'd1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_gnt[i]) begin
                req_active[i] = 1'b0;
                gnt_log.push_back(i);
            end
        end
        if (rsp_valid != '0) rsp_log.push_back(oh_idx(rsp_valid));
    endtask

    task automatic clear_env();
        exp_q.delete();
        pend_q.delete();
        gnt_log.delete();
        rsp_log.delete();
        hold_dv = 0; force_dv = 0; wr_hold = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_active[i] = 1'b0;
            req_av[i]     = '0;
        end
        req_read = '0; req_addr = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_env();
        #1;
        check("reset_mem_read", 64'(mem_read), 64'd0);
        check("reset_mem_address", 64'(mem_address), 64'd0);
        check("reset_gnt", 64'(req_gnt), 64'd0);
        check("reset_rsp", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err_unexpected), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0 || pend_q.size() != 0 || any_active()) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) $display("FAIL drain_%s: still busy after %0d cycles", name, budget);
        check({"drain_", name}, 64'(n < budget), 64'd1);
    endtask

    // Monitor: retires scoreboard entries and checks each grant against the request it answers.
    logic [NUM_REQ-1:0]    prev_req, prev_gnt;
    logic [NUM_REQ*AW-1:0] prev_addr;
    always @(negedge clk) begin
        int  g, kk;
        bit  found;
        #2;
        if (!rst_n) begin
            prev_req = '0;
            prev_gnt = '0;
        end else begin
            if (rsp_valid != '0) begin
                check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                g = oh_idx(rsp_valid);
                found = 0; kk = 0;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (!found && exp_q[k].req == g) begin found = 1; kk = k; end
                end
                check("rsp_owner_pending", 64'(found), 64'd1);
                if (found) begin
                    check("rsp_data", rsp_data, exp_q[kk].data);
                    exp_q.delete(kk);
                end
            end
            if (req_gnt != '0) begin
                check("gnt_onehot", 64'($onehot(req_gnt)), 64'd1);
                g = oh_idx(req_gnt);
                check("gnt_requested", 64'(req_read[g]), 64'd1);
                check("gnt_address", 64'(mem_address), 64'(req_addr[g*AW +: AW]));
                check("gnt_mem_read", 64'(mem_read), 64'd1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prev_req[i] && !prev_gnt[i]) begin
                    assert (req_read[i] && req_addr[i*AW +: AW] == prev_addr[i*AW +: AW])
                    else $error("protocol: requester %0d changed its request before grant", i);
                end
            end
            prev_req  = req_read;
            prev_gnt  = req_gnt;
            prev_addr = req_addr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom};
        clear_env();

        // Single read, latency 2.
        apply_reset();
        request(1, 4'd3);
        tick();
        check("t1_idle_mem_read", 64'(s_mem_read), 64'd0);
        check("t1_idle_gnt", 64'(s_gnt), 64'd0);
        tick();
        check("t1_mem_read", 64'(s_mem_read), 64'd1);
        check("t1_addr", 64'(s_addr), 64'd3);
        check("t1_gnt", 64'(s_gnt), 64'b0010);
        tick();
        check("t1_no_rsp_yet", 64'(s_rsp), 64'd0);
        tick();
        check("t1_rsp", 64'(s_rsp), 64'b0010);
        wait_idle("t1", 50);

        // All requesters at once: round-robin from requester 0, back-to-back.
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) request(i, AW'(i));
        tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            tick();
            check("t2_gnt_order", 64'(s_gnt), 64'(1 << i));
            check("t2_addr", 64'(s_addr), 64'(i));
        end
        wait_idle("t2", 50);
        check("t2_rsp_count", 64'(rsp_log.size()), 64'(NUM_REQ));
        for (int i = 0; i < rsp_log.size(); i++) check("t2_rsp_order", 64'(rsp_log[i]), 64'(i));

        // Waitrequest stall on the first command.
        apply_reset();
        wr_hold = 3;
        request(0, 4'd5);
        request(1, 4'd6);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_mem_read", 64'(s_mem_read), 64'd1);
            check("t3_hold_addr", 64'(s_addr), 64'd5);
            check("t3_hold_no_gnt", 64'(s_gnt), 64'd0);
        end
        tick();
        check("t3_gnt0", 64'(s_gnt), 64'b0001);
        tick();
        check("t3_gnt1", 64'(s_gnt), 64'b0010);
        check("t3_addr1", 64'(s_addr), 64'd6);
        wait_idle("t3", 50);

        // Credit limit: responses withheld.
        apply_reset();
        hold_dv = 1;
        for (int i = 0; i < NUM_REQ; i++) request(i, AW'(i + 8));
        tick();
        tick();
        request(0, 4'd12);
        repeat (3) tick();
        repeat (3) begin
            tick();
            check("t4_blocked_mem_read", 64'(s_mem_read), 64'd0);
            check("t4_blocked_busy", 64'(s_busy), 64'd1);
        end
        check("t4_grant_count", 64'(gnt_log.size()), 64'(MAX_OUT));
        hold_dv = 0;
        tick();
        check("t4_first_rsp", 64'(s_rsp), 64'b0001);
        check("t4_credit_cycle_idle", 64'(s_mem_read), 64'd0);
        tick();
        check("t4_select_cycle_idle", 64'(s_mem_read), 64'd0);
        tick();
        check("t4_reissue", 64'(s_mem_read), 64'd1);
        check("t4_reissue_gnt", 64'(s_gnt), 64'b0001);
        check("t4_reissue_addr", 64'(s_addr), 64'd12);
        wait_idle("t4", 50);

        // Unexpected readdatavalid.
        force_dv = 1;
        tick();
        check("t5_no_rsp", 64'(s_rsp), 64'd0);
        check("t5_err_before", 64'(s_err), 64'd0);
        repeat (3) begin
            tick();
            check("t5_err_sticky", 64'(s_err), 64'd1);
        end

        // Asynchronous reset with reads outstanding and a command stalled.
        hold_dv = 1;
        request(0, 4'd1);
        request(1, 4'd2);
        request(2, 4'd9);
        repeat (3) tick();
        wr_hold = 5;
        tick();
        check("t6_pre_mem_read", 64'(s_mem_read), 64'd1);
        check("t6_pre_busy", 64'(s_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_mem_read", 64'(mem_read), 64'd0);
        check("t6_async_addr", 64'(mem_address), 64'd0);
        check("t6_async_busy", 64'(busy), 64'd0);
        check("t6_async_err", 64'(err_unexpected), 64'd0);
        check("t6_async_gnt", 64'(req_gnt), 64'd0);
        clear_env();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        request(1, 4'd4);
        request(0, 4'd7);
        wait_idle("t6", 50);
        check("t6_gnt_count", 64'(gnt_log.size()), 64'd2);
        if (gnt_log.size() == 2) begin
            check("t6_first_gnt", 64'(gnt_log[0]), 64'd0);
            check("t6_second_gnt", 64'(gnt_log[1]), 64'd1);
        end

        // Randomized traffic, stalls and response gaps.
        apply_reset();
        rand_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_active[i] && $urandom_range(2) == 0) request(i, AW'($urandom_range(15)));
        end
        wait_idle("random", 400);
        check("random_err", 64'(err_unexpected), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
